if_prefetch_stage: RTL



---
 rtl/if_prefetch_stage.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: credit-limited prefetch queue over a pipelined req/gnt memory port.
// Defining IF_PREFETCH_BPRED_EN adds a static JAL/backward-branch predictor.
module if_prefetch_stage #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn_i,
    input  logic        flush_i,
    input  logic        branch_i,
    input  logic [31:0] pc_i,
    input  logic        halt_i,
    input  logic        ack_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        br_pred_o,
    output logic        req_o,
    output logic [31:0] addr_o,
    input  logic        gnt_i,
    input  logic        rvalid_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] dbg_pc_o
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [31:0] r_fpc;
    logic [31:0] r_q_instr [FIFO_DEPTH];
    logic [31:0] r_q_pc    [FIFO_DEPTH];
    ptr_t        r_q_rptr, r_q_wptr;
    cnt_t        r_q_count;
    logic [31:0] r_pf_pc   [FIFO_DEPTH];
    ptr_t        r_pf_rptr, r_pf_wptr;
    cnt_t        r_outstanding;
    cnt_t        r_drop;

    logic        w_redirect, w_accept, w_pop, w_grant, w_req, w_pred_taken;
    logic [CW:0] w_inflight;
    logic [31:0] w_pf_head;

    assign w_redirect = flush_i | branch_i;
    assign w_pf_head  = r_pf_pc[r_pf_rptr];
    assign w_accept   = rvalid_i && !w_redirect && (r_drop == '0);
    assign w_pop      = ack_i && (r_q_count != '0) && !w_redirect;
    // Credit covers buffered entries plus every in-flight fetch, including ones to be dropped.
    assign w_inflight = {1'b0, r_q_count} + {1'b0, r_outstanding};
    assign w_req      = rstn_i && !halt_i && !w_redirect && !w_pred_taken && (w_inflight < DEPTH_C);
    assign w_grant    = w_req && gnt_i;

`ifdef IF_PREFETCH_BPRED_EN
    logic        r_q_pred [FIFO_DEPTH];
    logic [31:0] w_j_imm, w_b_imm, w_pred_target;
    logic        w_is_jal, w_is_bneg;

    assign w_j_imm       = {{12{rdata_i[31]}}, rdata_i[19:12], rdata_i[20], rdata_i[30:21], 1'b0};
    assign w_b_imm       = {{20{rdata_i[31]}}, rdata_i[7], rdata_i[30:25], rdata_i[11:8], 1'b0};
    assign w_is_jal      = (rdata_i[6:0] == 7'b1101111);
    assign w_is_bneg     = (rdata_i[6:0] == 7'b1100011) && rdata_i[31];
    assign w_pred_taken  = w_accept && (w_is_jal || w_is_bneg);
    assign w_pred_target = w_pf_head + (w_is_jal ? w_j_imm : w_b_imm);
    assign br_pred_o     = valid_o ? r_q_pred[r_q_rptr] : 1'b0;
`else
    assign w_pred_taken  = 1'b0;
    assign br_pred_o     = 1'b0;
`endif

    assign valid_o  = (r_q_count != '0);
    assign instr_o  = valid_o ? r_q_instr[r_q_rptr] : 32'h0;
    assign pc_o     = valid_o ? r_q_pc[r_q_rptr] : 32'h0;
    assign req_o    = w_req;
    assign addr_o   = r_fpc;
    assign dbg_pc_o = r_fpc;

    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            r_fpc         <= RESET_PC;
            r_q_rptr      <= '0;
            r_q_wptr      <= '0;
            r_q_count     <= '0;
            r_pf_rptr     <= '0;
            r_pf_wptr     <= '0;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_outstanding <= r_outstanding + cnt_t'(w_grant) - cnt_t'(rvalid_i);
            if (w_redirect) begin
                // Every outstanding fetch is stale now, so earlier pending drops are already included.
                r_fpc     <= pc_i;
                r_drop    <= (rvalid_i && r_outstanding != '0) ? r_outstanding - cnt_t'(1) : r_outstanding;
                r_q_rptr  <= '0;
                r_q_wptr  <= '0;
                r_q_count <= '0;
                r_pf_rptr <= '0;
                r_pf_wptr <= '0;
            end else begin
                if (w_grant) begin
                    r_fpc     <= r_fpc + 32'd4;
                    r_pf_wptr <= r_pf_wptr + ptr_t'(1);
                end
                if (rvalid_i) begin
                    if (r_drop != '0)
                        r_drop <= r_drop - cnt_t'(1);
                    else
                        r_pf_rptr <= r_pf_rptr + ptr_t'(1);
                end
`ifdef IF_PREFETCH_BPRED_EN
                if (w_pred_taken) begin
                    r_fpc     <= w_pred_target;
                    r_drop    <= r_outstanding - cnt_t'(1);
                    r_pf_rptr <= '0;
                    r_pf_wptr <= '0;
                end
`endif
                if (w_accept)
                    r_q_wptr <= r_q_wptr + ptr_t'(1);
                if (w_pop)
                    r_q_rptr <= r_q_rptr + ptr_t'(1);
                if (w_accept && !w_pop)
                    r_q_count <= r_q_count + cnt_t'(1);
                else if (!w_accept && w_pop)
                    r_q_count <= r_q_count - cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_grant)
            r_pf_pc[r_pf_wptr] <= r_fpc;
        if (w_accept) begin
            r_q_instr[r_q_wptr] <= rdata_i;
            r_q_pc[r_q_wptr]    <= w_pf_head;
`ifdef IF_PREFETCH_BPRED_EN
            r_q_pred[r_q_wptr]  <= w_pred_taken;
`endif
        end
    end
endmodule
